pulse_gen: RTL

Single-cycle-tick to level-pulse generator: the transmit-side counterpart of the edge detector, which turns a level into a one-cycle tick. Each accepted `tick` produces a clean `level` pulse of programmable length followed by a guaranteed low gap, so a downstream edge detector sees exactly one rising edge per accepted tick. It sits between control logic that issues strobes and any consumer expecting a stretched, edge-detectable level.

---
 rtl/pulse_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pulse_gen.sv
// pulse_gen: turns a one-cycle tick into a level pulse of programmable length,
// followed by a forced low gap, so a downstream edge detector sees exactly one
// rising edge per accepted tick.
//
// Parameters:
//   W           width of len and of the pulse/gap down-counters
//   GAP_CYCLES  forced low cycles after each pulse (0 .. 2^W-1)
//
// Ports:
//   clk    clock, all logic on the rising edge
//   rst    synchronous active-high reset
//   tick   one-cycle request strobe
//   len    pulse length in cycles, sampled on acceptance (0 behaves as 1)
//   level  generated pulse (registered)
//   busy   high whenever the FSM is not idle (registered)
//   done   one-cycle strobe on the first low cycle after a pulse (registered)
//   drop   one-cycle strobe the cycle after an ignored tick (registered)
//
// Optional feature: define PULSE_GEN_RETRIGGER_EN to let a tick during HIGH
// reload the pulse counter instead of being dropped.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for tick; level=0, busy=0
// HIGH  | pulse in progress; level=1, cnt counts remaining cycles-1
// GAP   | forced low gap; level=0, busy=1, gcnt counts remaining-1

module pulse_gen #(
  parameter int W          = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] len,
  output logic         level,
  output logic         busy,
  output logic         done,
  output logic         drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [W-1:0] GAP_M1 = (GAP_CYCLES > 0) ? W'(GAP_CYCLES - 1) : '0;

  state_t       state, state_nx;
  logic [W-1:0] cnt, cnt_nx;
  logic [W-1:0] gcnt, gcnt_nx;
  logic         done_nx, drop_nx;
  logic [W-1:0] len_m1;

  // A zero length is stretched to a single cycle.
  assign len_m1 = (len == '0) ? '0 : len - W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      gcnt  <= '0;
      level <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      drop  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      gcnt  <= gcnt_nx;
      // Outputs are registered copies of the decoded next state so they
      // line up with the state they describe.
      level <= (state_nx == HIGH);
      busy  <= (state_nx != IDLE);
      done  <= done_nx;
      drop  <= drop_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gcnt_nx  = gcnt;
    done_nx  = 1'b0;
    drop_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (tick) begin
          cnt_nx   = len_m1;
          state_nx = HIGH;
        end
      end

      HIGH: begin
`ifdef PULSE_GEN_RETRIGGER_EN
        if (tick) begin
          // Reload extends the pulse; no done and no drop for this tick.
          cnt_nx = len_m1;
        end else if (cnt != '0) begin
          cnt_nx = cnt - W'(1);
        end else begin
          done_nx = 1'b1;
          if (GAP_CYCLES > 0) begin
            gcnt_nx  = GAP_M1;
            state_nx = GAP;
          end else begin
            state_nx = IDLE;
          end
        end
`else
        if (tick) begin
          drop_nx = 1'b1;
        end
        if (cnt != '0) begin
          cnt_nx = cnt - W'(1);
        end else begin
          done_nx = 1'b1;
          if (GAP_CYCLES > 0) begin
            gcnt_nx  = GAP_M1;
            state_nx = GAP;
          end else begin
            state_nx = IDLE;
          end
        end
`endif
      end

      GAP: begin
        if (tick) begin
          drop_nx = 1'b1;
        end
        if (gcnt == '0) begin
          state_nx = IDLE;
        end else begin
          gcnt_nx = gcnt - W'(1);
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
